img_get_grads_divseq: RTL and testbench
=======================================

// Module: img_get_grads_divseq
// PURPOSE
//  Sequential unsigned radix-2 restoring divider. It is the inverse companion of the img_get_grads
//  13x13 multiplier: it divides a 26-bit product-domain value (e.g. a gradient magnitude
//  accumulation) by a 13-bit divisor to return to pixel scale.
//  Sits in img_get_grads between the accumulate stage and the output formatter, using valid/ready
//  handshakes on both sides. One division is in flight at a time, with no pipelining.
// PARAMETERS
//  DIVIDEND_WIDTH  26  width of dividend and quotient
//  DIVISOR_WIDTH   13  width of divisor and remainder
// PORTS
//  ap_clk        in   1               clock, all state on rising edge
//  ap_rst_n      in   1               asynchronous reset, active-low
//  in_valid      in   1               dividend/divisor valid
//  in_ready      out  1               block accepts an operand pair
//  in_dividend   in   DIVIDEND_WIDTH  unsigned dividend
//  in_divisor    in   DIVISOR_WIDTH   unsigned divisor
//  out_valid     out  1               result valid
//  out_ready     in   1               downstream accepts result
//  out_quot      out  DIVIDEND_WIDTH  quotient
//  out_rem       out  DIVISOR_WIDTH   remainder
//  out_dbz       out  1               divisor was zero (present only with IMG_GET_GRADS_DIVSEQ_DBZ_EN)
// BEHAVIOUR
//  - State machine states: IDLE, BUSY, DONE.
//  - Reset state (async on ap_rst_n=0): state=IDLE, out_valid=0, out_quot=0, out_rem=0, out_dbz=0,
//    iteration counter=0. in_ready=(state==IDLE), so in_ready is 1 during and after reset.
//  - IDLE: on in_valid&&in_ready, latch the dividend into the quotient shift register, latch the
//    divisor, clear the partial remainder (DIVISOR_WIDTH+1 bits), load the counter with
//    DIVIDEND_WIDTH, and go to BUSY.
//  - BUSY: one quotient bit per cycle, MSB first. Each step:
//      - t = {rem, q[MSB]} - {1'b0, divisor}
//      - if t is non-negative: rem = t and the new quotient bit is 1
//      - otherwise: rem = {rem, q[MSB]} and the new quotient bit is 0
//      - the counter decrements
//  - Leaving BUSY: on the step where the counter reaches 0, go to DONE and set out_valid=1.
//    out_valid therefore rises exactly DIVIDEND_WIDTH cycles after the accepting edge.
//  - DONE: out_quot, out_rem and out_dbz are held stable while out_ready=0. On out_valid&&out_ready:
//    out_valid=0 and state=IDLE, so in_ready=1 on the next cycle.
//  - Throughput: one result every DIVIDEND_WIDTH+2 cycles at best. in_valid is ignored unless the
//    state is IDLE.
//  - Inputs are sampled only at the accepting edge. Changes on in_* while BUSY have no effect.
//  - Divisor==0: quotient is all ones and out_rem = dividend[DIVISOR_WIDTH-1:0]. This matches the
//    natural restoring result with the remainder truncated.
//  - Dividend<divisor: quotient 0, remainder = dividend.
//  - Reset mid-BUSY or mid-DONE: the operation is dropped and no result is emitted. The block
//    returns to IDLE with the reset values above.
//  - out_quot and out_rem change only on the edge that enters DONE.
// CONFIGURATION
//  IMG_GET_GRADS_DIVSEQ_DBZ_EN defined:
//    - the out_dbz port exists
//    - when divisor==0 at acceptance, BUSY is skipped: the next state is DONE with out_valid=1 one
//      cycle after acceptance, out_dbz=1, quotient all ones and out_rem = dividend low bits
//    - out_dbz=0 for every non-zero divisor
//  IMG_GET_GRADS_DIVSEQ_DBZ_EN undefined:
//    - no out_dbz port
//    - a zero divisor iterates the full DIVIDEND_WIDTH cycles and produces the same values
// TESTING
//  - Divide: 100000/13 -> out_valid 26 cycles after accept; quot=7692, rem=4.
//  - Boundary: 67108863/8191 -> quot=8193, rem=0; 5/9 -> quot=0, rem=5.
//  - Zero divisor: 1234/0 -> quot=0x3FFFFFF, rem=1234. With the macro, out_valid 1 cycle after
//    accept and out_dbz=1; without it, 26 cycles.
//  - Backpressure: out_ready held 0 for 10 cycles in DONE -> out_valid=1 and data stable, in_ready=0;
//    release -> in_ready=1 on the next cycle.
//  - Back-to-back: in_valid held high with two operand pairs -> second is accepted only after the
//    first result handshake; both results correct.
//  - Reset: ap_rst_n pulsed low at iteration 10 -> out_valid=0, in_ready=1; next op 1000/7 gives
//    quot=142, rem=6.

Source files
------------

// File: rtl/img_get_grads_divseq.sv
// -----------------------------------------------------------------------------
// img_get_grads_divseq
//
// Sequential unsigned radix-2 restoring divider. Companion of the img_get_grads
// 13x13 multiplier: divides a product-domain value back down to pixel scale.
// One division is in flight at a time; one quotient bit is produced per clock,
// MSB first.
//
// Optional feature (macro IMG_GET_GRADS_DIVSEQ_DBZ_EN):
//   Adds the out_dbz port and short-circuits a zero divisor straight to DONE
//   one cycle after acceptance. Without the macro a zero divisor iterates the
//   full DIVIDEND_WIDTH steps and yields the same quotient/remainder values.
//
// Ports:
//   ap_clk       in   clock, all state on rising edge
//   ap_rst_n     in   asynchronous reset, active-low
//   in_valid     in   dividend/divisor valid
//   in_ready     out  block idle and able to accept an operand pair
//   in_dividend  in   unsigned dividend  [DIVIDEND_WIDTH]
//   in_divisor   in   unsigned divisor   [DIVISOR_WIDTH]
//   out_valid    out  result valid (held until out_ready)
//   out_ready    in   downstream accepts result
//   out_quot     out  quotient  [DIVIDEND_WIDTH]
//   out_rem      out  remainder [DIVISOR_WIDTH]
//   out_dbz      out  divisor was zero (only with IMG_GET_GRADS_DIVSEQ_DBZ_EN)
// -----------------------------------------------------------------------------
module img_get_grads_divseq #(
    parameter int DIVIDEND_WIDTH = 26,
    parameter int DIVISOR_WIDTH  = 13
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIVIDEND_WIDTH-1:0] in_dividend,
    input  logic [DIVISOR_WIDTH-1:0]  in_divisor,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIVIDEND_WIDTH-1:0] out_quot,
    output logic [DIVISOR_WIDTH-1:0]  out_rem
`ifdef IMG_GET_GRADS_DIVSEQ_DBZ_EN
    ,
    output logic                      out_dbz
`endif
);

    // Partial remainder carries one guard bit above the divisor width.
    localparam int REM_W = DIVISOR_WIDTH + 1;
    localparam int CNT_W = $clog2(DIVIDEND_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [DIVIDEND_WIDTH-1:0] out_quot_q, out_quot_d;
    logic [DIVISOR_WIDTH-1:0]  out_rem_q, out_rem_d;
`ifdef IMG_GET_GRADS_DIVSEQ_DBZ_EN
    logic                      out_dbz_q, out_dbz_d;
`endif

    // Datapath working registers: no reset, they are always loaded on accept.
    logic [DIVIDEND_WIDTH-1:0] q_q, q_d;
    logic [DIVISOR_WIDTH-1:0]  div_q, div_d;
    logic [REM_W-1:0]          rem_q, rem_d;

    // One restoring step: shift the next dividend bit into the remainder and
    // try to subtract the divisor. With a zero divisor the subtraction always
    // succeeds, so the remainder just accumulates (and truncates) dividend bits.
    logic [REM_W:0]            shifted;
    logic [REM_W:0]            div_ext;
    logic                      qbit;
    logic [REM_W-1:0]          step_rem;
    logic                      accept;

    assign shifted  = {rem_q, q_q[DIVIDEND_WIDTH-1]};
    assign div_ext  = {2'b00, div_q};
    assign qbit     = (shifted >= div_ext);
    assign step_rem = qbit ? REM_W'(shifted - div_ext) : shifted[REM_W-1:0];

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;

    assign out_quot  = out_quot_q;
    assign out_rem   = out_rem_q;
`ifdef IMG_GET_GRADS_DIVSEQ_DBZ_EN
    assign out_dbz   = out_dbz_q;
`endif

    // Next-state and datapath control.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        out_quot_d = out_quot_q;
        out_rem_d  = out_rem_q;
`ifdef IMG_GET_GRADS_DIVSEQ_DBZ_EN
        out_dbz_d  = out_dbz_q;
`endif
        q_d        = q_q;
        div_d      = div_q;
        rem_d      = rem_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    q_d     = in_dividend;
                    div_d   = in_divisor;
                    rem_d   = '0;
                    cnt_d   = CNT_W'(DIVIDEND_WIDTH);
                    state_d = BUSY;
`ifdef IMG_GET_GRADS_DIVSEQ_DBZ_EN
                    // Zero divisor: the iterative result is known up front.
                    if (in_divisor == '0) begin
                        cnt_d      = '0;
                        out_quot_d = '1;
                        out_rem_d  = in_dividend[DIVISOR_WIDTH-1:0];
                        out_dbz_d  = 1'b1;
                        state_d    = DONE;
                    end
`endif
                end
            end

            BUSY: begin
                q_d   = {q_q[DIVIDEND_WIDTH-2:0], qbit};
                rem_d = step_rem;
                cnt_d = cnt_q - CNT_W'(1);
                // Last step: publish the result on the same edge that enters DONE.
                if (cnt_q == CNT_W'(1)) begin
                    out_quot_d = {q_q[DIVIDEND_WIDTH-2:0], qbit};
                    out_rem_d  = step_rem[DIVISOR_WIDTH-1:0];
`ifdef IMG_GET_GRADS_DIVSEQ_DBZ_EN
                    out_dbz_d  = 1'b0;
`endif
                    state_d    = DONE;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and result registers.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            out_quot_q <= '0;
            out_rem_q  <= '0;
`ifdef IMG_GET_GRADS_DIVSEQ_DBZ_EN
            out_dbz_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            out_quot_q <= out_quot_d;
            out_rem_q  <= out_rem_d;
`ifdef IMG_GET_GRADS_DIVSEQ_DBZ_EN
            out_dbz_q  <= out_dbz_d;
`endif
        end
    end

    // Working registers.
    always_ff @(posedge ap_clk) begin
        q_q   <= q_d;
        div_q <= div_d;
        rem_q <= rem_d;
    end

endmodule

// File: tb/tb_img_get_grads_divseq.sv
// -----------------------------------------------------------------------------
// tb_img_get_grads_divseq
//
// Scoreboard bench for img_get_grads_divseq. The driver pushes the expected
// result (plain integer division) at each accepting edge; an independent
// monitor pops and compares whenever the DUT presents a result.
// -----------------------------------------------------------------------------
module tb_img_get_grads_divseq;

    localparam int DW = 26;
    localparam int VW = 13;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_dividend = '0;
    logic [VW-1:0] in_divisor = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_quot;
    logic [VW-1:0] out_rem;
`ifdef IMG_GET_GRADS_DIVSEQ_DBZ_EN
    logic          out_dbz;
`endif

    img_get_grads_divseq #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW)) dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_dividend (in_dividend),
        .in_divisor  (in_divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_quot    (out_quot),
        .out_rem     (out_rem)
`ifdef IMG_GET_GRADS_DIVSEQ_DBZ_EN
        ,
        .out_dbz     (out_dbz)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          dbz;
        longint        acc;
        int            lat;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    bit   rdy_en  = 1'b0;
    bit   rdy_val = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: plain integer division, zero divisor per the block's rules.
    function automatic exp_t model(input logic [DW-1:0] a, input logic [VW-1:0] b);
        exp_t e;
        if (b == 0) begin
            e.q   = {DW{1'b1}};
            e.r   = a[VW-1:0];
            e.dbz = 1'b1;
`ifdef IMG_GET_GRADS_DIVSEQ_DBZ_EN
            e.lat = 1;
`else
            e.lat = DW;
`endif
        end else begin
            e.q   = DW'(a / b);
            e.r   = VW'(a % b);
            e.dbz = 1'b0;
            e.lat = DW;
        end
        e.acc = 0;
        return e;
    endfunction

    // Downstream ready: random unless forced by the stimulus.
    always @(posedge ap_clk) begin
        #2;
        out_ready = rdy_en ? rdy_val : ($urandom_range(0, 2) != 0);
    end

    // Offer one operand pair; push the expectation at the accepting edge.
    task automatic send(input logic [DW-1:0] a, input logic [VW-1:0] b, input bit hold);
        exp_t e;
        int   wc;
        @(negedge ap_clk);
        in_dividend = a;
        in_divisor  = b;
        in_valid    = 1'b1;
        wc = 0;
        while (!in_ready && wc < 300) begin
            @(negedge ap_clk);
            wc++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        // One division in flight: the previous result must have been consumed.
        chk("accept_only_when_drained", exp_q.size(), 0);
        @(posedge ap_clk);
        e = model(a, b);
        e.acc = longint'($time);
        exp_q.push_back(e);
        if (!hold) begin
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic drain(input int limit);
        int wc;
        wc = 0;
        while (exp_q.size() != 0 && wc < limit) begin
            @(negedge ap_clk);
            wc++;
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    // Monitor: compares each presented result against the scoreboard head.
    bit            seen = 1'b0;
    bit            chk_next = 1'b0;
    logic [DW-1:0] hold_q;
    logic [VW-1:0] hold_r;

    always @(negedge ap_clk) begin
        exp_t e;
        if (!ap_rst_n) begin
            seen     = 1'b0;
            chk_next = 1'b0;
        end else begin
            if (chk_next) begin
                chk("in_ready_after_handshake", in_ready, 1);
                chk_next = 1'b0;
            end
            if (out_valid) begin
                if (!seen) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out_valid", 1, 0);
                    end else begin
                        e = exp_q[0];
                        chk("quot", out_quot, e.q);
                        chk("rem", out_rem, e.r);
                        chk("latency", ((longint'($time) - 5) - e.acc) / 10, e.lat);
`ifdef IMG_GET_GRADS_DIVSEQ_DBZ_EN
                        chk("dbz", out_dbz, e.dbz);
`endif
                    end
                    hold_q = out_quot;
                    hold_r = out_rem;
                    seen   = 1'b1;
                end else begin
                    chk("quot_stable", out_quot, hold_q);
                    chk("rem_stable", out_rem, hold_r);
                    chk("in_ready_low_in_done", in_ready, 0);
                end
                if (out_ready) begin
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                    end
                    seen     = 1'b0;
                    chk_next = 1'b1;
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] a;
        logic [VW-1:0] b;
        int            wc;

        // Reset values.
        #2 ap_rst_n = 1'b0;
        @(negedge ap_clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_quot", out_quot, 0);
        chk("rst_out_rem", out_rem, 0);
        repeat (2) @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;

        // Directed values and boundaries.
        send(26'd100000, 13'd13, 1'b0);
        send(26'd67108863, 13'd8191, 1'b0);
        send(26'd5, 13'd9, 1'b0);
        send(26'd1234, 13'd0, 1'b0);
        send(26'd8191, 13'd8191, 1'b0);
        send(26'd0, 13'd1, 1'b0);
        drain(200);

        // Backpressure: hold out_ready low for 10 cycles in DONE.
        rdy_en  = 1'b1;
        rdy_val = 1'b0;
        send(26'd4321, 13'd17, 1'b0);
        wc = 0;
        while (!out_valid && wc < 100) begin
            @(negedge ap_clk);
            wc++;
        end
        chk("bp_reach_done", out_valid, 1);
        repeat (10) begin
            @(negedge ap_clk);
            chk("bp_valid_held", out_valid, 1);
        end
        rdy_val = 1'b1;
        drain(50);
        rdy_en = 1'b0;

        // Back-to-back with in_valid held high.
        send(26'd33554431, 13'd3, 1'b1);
        send(26'd77777, 13'd0, 1'b0);
        drain(200);

        // Reset in the middle of an iteration.
        rdy_en  = 1'b1;
        rdy_val = 1'b1;
        send(26'd100000, 13'd13, 1'b0);
        repeat (10) @(posedge ap_clk);
        #1 ap_rst_n = 1'b0;
        exp_q.delete();
        @(negedge ap_clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        repeat (40) begin
            @(negedge ap_clk);
            chk("no_result_after_reset", out_valid, 0);
        end
        send(26'd1000, 13'd7, 1'b0);
        drain(100);
        rdy_en = 1'b0;

        // Randomized operands.
        for (int i = 0; i < 60; i++) begin
            a = DW'($urandom());
            case ($urandom_range(0, 4))
                0:       b = '0;
                1:       b = VW'($urandom_range(1, 15));
                2: begin
                    b = VW'($urandom_range(1, 8191));
                    a = DW'($urandom_range(0, 32'(b) - 1));
                end
                default: b = VW'($urandom());
            endcase
            send(a, b, ($urandom_range(0, 1) == 1));
            repeat ($urandom_range(0, 3)) @(negedge ap_clk);
        end
        @(negedge ap_clk);
        in_valid = 1'b0;
        drain(300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
